// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen_if : enable input and raster timing outputs of the        |
// | VGA timing generator.  Revision 1.0                                      |
// +--------------------------------------------------------------------------+
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          en;
  logic          pix_tick;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          h_sync;
  logic          v_sync;
  logic          vd_on;
  logic          sol;
  logic          sof;
  logic          eof;
  logic [15:0]   frame_count;

  modport master (
    input  en,
    output pix_tick, h_count, v_count, h_sync, v_sync, vd_on,
           sol, sof, eof, frame_count
  );

  modport slave (
    output en,
    input  pix_tick, h_count, v_count, h_sync, v_sync, vd_on,
           sol, sof, eof, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen : pixel-divided raster counters with registered sync,     |
// | blanking and line/frame strobes.  Revision 1.0                           |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 11
) (
  input  logic            clk,
  input  logic            rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // One spare bit so window bounds equal to 2^CW still compare correctly
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0]    div_q, div_d;
  logic [CW-1:0] h_count_q, h_count_d;
  logic [CW-1:0] v_count_q, v_count_d;
  logic [15:0]   frame_count_q;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          vd_on_q, vd_on_d;
  logic          sol_q, sol_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic          tick;

  assign tick = bus.en & ~rst & (div_q == DIV_LAST);

  always_comb begin
    div_d     = div_q;
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (bus.en) begin
      div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    end
    if (tick) begin
      h_count_d = (h_count_q == H_LAST) ? '0 : h_count_q + CW'(1);
      if (h_count_q == H_LAST) begin
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + CW'(1);
      end
    end
  end

  // Flags decode the next counts so they line up with the counts they describe
  always_comb begin
    h_sync_d = (({1'b0, h_count_d} >= H_SYNC_BEG) && ({1'b0, h_count_d} <= H_SYNC_END))
               ? H_POL : ~H_POL;
    v_sync_d = (({1'b0, v_count_d} >= V_SYNC_BEG) && ({1'b0, v_count_d} <= V_SYNC_END))
               ? V_POL : ~V_POL;
    vd_on_d  = ({1'b0, h_count_d} < H_ACT_END) && ({1'b0, v_count_d} < V_ACT_END);
    sol_d    = tick && (h_count_d == '0);
    sof_d    = tick && (h_count_d == '0) && (v_count_d == '0);
    eof_d    = tick && (h_count_d == H_LAST) && (v_count_d == V_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= 4'd0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_count_q <= 16'd0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      vd_on_q       <= 1'b1;
      sol_q         <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
    end else begin
      div_q <= div_d;
      sol_q <= sol_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
      if (tick) begin
        h_count_q <= h_count_d;
        v_count_q <= v_count_d;
        h_sync_q  <= h_sync_d;
        v_sync_q  <= v_sync_d;
        vd_on_q   <= vd_on_d;
      end
      if (sof_d) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  // Strobes are masked so a pause never shows a stale one-cycle pulse
  assign bus.pix_tick    = tick;
  assign bus.h_count     = h_count_q;
  assign bus.v_count     = v_count_q;
  assign bus.h_sync      = h_sync_q;
  assign bus.v_sync      = v_sync_q;
  assign bus.vd_on       = vd_on_q;
  assign bus.sol         = sol_q & bus.en;
  assign bus.sof         = sof_q & bus.en;
  assign bus.eof         = eof_q & bus.en;
  assign bus.frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_timing_gen : directed bench for default and small-raster          |
// | configurations.  Revision 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

  logic clk;
  logic rst_d;
  logic rst_s;
  int   n_tests;
  int   n_fail;

  vga_timing_gen_if #(.CW(11)) bd ();
  vga_timing_gen_if #(.CW(11)) bs ();

  vga_timing_gen dut_d (
    .clk (clk),
    .rst (rst_d),
    .bus (bd)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .H_POL(1'b1), .V_POL(1'b1), .CW(11)
  ) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (bs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for the cycle in which h_count first shows target
  task automatic wait_h(input logic [10:0] target, input int budget);
    logic [10:0] prev;
    prev = bd.h_count;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (bd.h_count == target && prev != target) return;
      prev = bd.h_count;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_h: h_count=%0d never reached %0d", bd.h_count, target);
  endtask

  task automatic jump_d(input logic [10:0] h, input logic [10:0] v);
    bd.en = 1'b0;
    force dut_d.h_count_q = h;
    force dut_d.v_count_q = v;
    #1;
    release dut_d.h_count_q;
    release dut_d.v_count_q;
    bd.en = 1'b1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bd.h_count, bd.v_count, bd.frame_count, bd.pix_tick, bd.h_sync, bd.v_sync,
         bd.vd_on, bd.sol, bd.sof, bd.eof} !== {11'd0, 11'd0, 16'd0, 7'b0111000}) begin
      n_fail++;
      $display("FAIL reset_default: got h=%0d v=%0d f=%0d tick=%b hs=%b vs=%b vd=%b sol=%b sof=%b eof=%b, want 0 0 0 0 1 1 1 0 0 0",
               bd.h_count, bd.v_count, bd.frame_count, bd.pix_tick, bd.h_sync, bd.v_sync,
               bd.vd_on, bd.sol, bd.sof, bd.eof);
    end
    n_tests++;
    if ({bs.h_count, bs.v_count, bs.frame_count, bs.pix_tick, bs.h_sync, bs.v_sync,
         bs.vd_on, bs.sol, bs.sof, bs.eof} !== {11'd0, 11'd0, 16'd0, 7'b0001000}) begin
      n_fail++;
      $display("FAIL reset_small: got h=%0d v=%0d f=%0d tick=%b hs=%b vs=%b vd=%b, want 0 0 0 0 0 0 1",
               bs.h_count, bs.v_count, bs.frame_count, bs.pix_tick, bs.h_sync, bs.v_sync, bs.vd_on);
    end
  endtask

  task automatic test_pix_tick();
    rst_d = 1'b0;
    step(3);
    n_tests++;
    if ({bd.pix_tick, bd.h_count} !== {1'b1, 11'd0}) begin
      n_fail++;
      $display("FAIL first_tick: got tick=%b h=%0d, want tick=1 h=0", bd.pix_tick, bd.h_count);
    end
    step(1);
    n_tests++;
    if ({bd.pix_tick, bd.h_count} !== {1'b0, 11'd1}) begin
      n_fail++;
      $display("FAIL first_advance: got tick=%b h=%0d, want tick=0 h=1", bd.pix_tick, bd.h_count);
    end
    step(3);
    n_tests++;
    if ({bd.pix_tick, bd.h_count} !== {1'b1, 11'd1}) begin
      n_fail++;
      $display("FAIL tick_period: got tick=%b h=%0d, want tick=1 h=1", bd.pix_tick, bd.h_count);
    end
  endtask

  task automatic test_hline();
    wait_h(11'd639, 4000);
    n_tests++;
    if (bd.vd_on !== 1'b1) begin n_fail++; $display("FAIL vd_639: got %b want 1", bd.vd_on); end
    wait_h(11'd640, 40);
    n_tests++;
    if (bd.vd_on !== 1'b0) begin n_fail++; $display("FAIL vd_640: got %b want 0", bd.vd_on); end
    wait_h(11'd655, 200);
    n_tests++;
    if (bd.h_sync !== 1'b1) begin n_fail++; $display("FAIL hs_655: got %b want 1", bd.h_sync); end
    wait_h(11'd656, 40);
    n_tests++;
    if (bd.h_sync !== 1'b0) begin n_fail++; $display("FAIL hs_656: got %b want 0", bd.h_sync); end
    wait_h(11'd751, 800);
    n_tests++;
    if (bd.h_sync !== 1'b0) begin n_fail++; $display("FAIL hs_751: got %b want 0", bd.h_sync); end
    wait_h(11'd752, 40);
    n_tests++;
    if (bd.h_sync !== 1'b1) begin n_fail++; $display("FAIL hs_752: got %b want 1", bd.h_sync); end
    wait_h(11'd799, 400);
    n_tests++;
    if (bd.v_count !== 11'd0) begin n_fail++; $display("FAIL v_at_799: got %0d want 0", bd.v_count); end
    wait_h(11'd0, 40);
    n_tests++;
    if ({bd.v_count, bd.sol, bd.sof} !== {11'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL h_wrap: got v=%0d sol=%b sof=%b, want v=1 sol=1 sof=0", bd.v_count, bd.sol, bd.sof);
    end
  endtask

  task automatic test_enable_hold();
    wait_h(11'd300, 2000);
    bd.en = 1'b0;
    step(10);
    n_tests++;
    if ({bd.h_count, bd.v_count, bd.frame_count, bd.pix_tick, bd.sol, bd.vd_on, bd.h_sync}
        !== {11'd300, 11'd1, 16'd0, 4'b0011}) begin
      n_fail++;
      $display("FAIL en_hold: got h=%0d v=%0d f=%0d tick=%b sol=%b vd=%b hs=%b, want 300 1 0 0 0 1 1",
               bd.h_count, bd.v_count, bd.frame_count, bd.pix_tick, bd.sol, bd.vd_on, bd.h_sync);
    end
    bd.en = 1'b1;
    step(3);
    n_tests++;
    if ({bd.pix_tick, bd.h_count} !== {1'b1, 11'd300}) begin
      n_fail++;
      $display("FAIL en_resume_tick: got tick=%b h=%0d, want tick=1 h=300", bd.pix_tick, bd.h_count);
    end
    step(1);
    n_tests++;
    if (bd.h_count !== 11'd301) begin n_fail++; $display("FAIL en_resume: got h=%0d want 301", bd.h_count); end
  endtask

  task automatic test_vsync_frame();
    jump_d(11'd798, 11'd489);
    wait_h(11'd0, 4000);
    n_tests++;
    if ({bd.v_count, bd.v_sync} !== {11'd490, 1'b0}) begin
      n_fail++; $display("FAIL vs_490: got v=%0d vs=%b, want 490 0", bd.v_count, bd.v_sync);
    end
    wait_h(11'd0, 4000);
    n_tests++;
    if ({bd.v_count, bd.v_sync} !== {11'd491, 1'b0}) begin
      n_fail++; $display("FAIL vs_491: got v=%0d vs=%b, want 491 0", bd.v_count, bd.v_sync);
    end
    wait_h(11'd0, 4000);
    n_tests++;
    if ({bd.v_count, bd.v_sync} !== {11'd492, 1'b1}) begin
      n_fail++; $display("FAIL vs_492: got v=%0d vs=%b, want 492 1", bd.v_count, bd.v_sync);
    end
    jump_d(11'd798, 11'd479);
    wait_h(11'd0, 4000);
    n_tests++;
    if ({bd.v_count, bd.vd_on} !== {11'd480, 1'b0}) begin
      n_fail++; $display("FAIL vd_480: got v=%0d vd=%b, want 480 0", bd.v_count, bd.vd_on);
    end
    jump_d(11'd798, 11'd524);
    wait_h(11'd799, 4000);
    n_tests++;
    if ({bd.v_count, bd.eof, bd.sof} !== {11'd524, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL eof_default: got v=%0d eof=%b sof=%b, want 524 1 0", bd.v_count, bd.eof, bd.sof);
    end
    step(1);
    n_tests++;
    if (bd.eof !== 1'b0) begin n_fail++; $display("FAIL eof_width: got %b want 0", bd.eof); end
    wait_h(11'd0, 40);
    n_tests++;
    if ({bd.v_count, bd.sof, bd.frame_count} !== {11'd0, 1'b1, 16'd1}) begin
      n_fail++; $display("FAIL v_wrap: got v=%0d sof=%b f=%0d, want 0 1 1", bd.v_count, bd.sof, bd.frame_count);
    end
  endtask

  task automatic test_mid_reset();
    bd.en = 1'b0;
    force dut_d.h_count_q     = 11'd400;
    force dut_d.v_count_q     = 11'd200;
    force dut_d.frame_count_q = 16'd3;
    #1;
    release dut_d.h_count_q;
    release dut_d.v_count_q;
    release dut_d.frame_count_q;
    step(1);
    n_tests++;
    if ({bd.h_count, bd.v_count, bd.frame_count} !== {11'd400, 11'd200, 16'd3}) begin
      n_fail++; $display("FAIL preload: got h=%0d v=%0d f=%0d, want 400 200 3", bd.h_count, bd.v_count, bd.frame_count);
    end
    bd.en = 1'b1;
    rst_d = 1'b1;
    #1;
    n_tests++;
    if ({bd.h_count, bd.v_count, bd.frame_count, bd.pix_tick, bd.h_sync, bd.v_sync,
         bd.vd_on, bd.sol, bd.sof, bd.eof} !== {11'd0, 11'd0, 16'd0, 7'b0111000}) begin
      n_fail++;
      $display("FAIL mid_reset: got h=%0d v=%0d f=%0d tick=%b hs=%b vs=%b vd=%b, want 0 0 0 0 1 1 1",
               bd.h_count, bd.v_count, bd.frame_count, bd.pix_tick, bd.h_sync, bd.v_sync, bd.vd_on);
    end
    step(2);
    rst_d = 1'b0;
    step(3);
    n_tests++;
    if ({bd.pix_tick, bd.h_count} !== {1'b1, 11'd0}) begin
      n_fail++; $display("FAIL rst_tick: got tick=%b h=%0d, want 1 0", bd.pix_tick, bd.h_count);
    end
    step(1);
    n_tests++;
    if (bd.h_count !== 11'd1) begin n_fail++; $display("FAIL rst_h1: got h=%0d want 1", bd.h_count); end
  endtask

  task automatic test_small();
    logic [63:0] got;
    logic [63:0] exp;
    string       nm;
    rst_s = 1'b0;
    #1;
    n_tests++;
    if (bs.pix_tick !== 1'b1) begin n_fail++; $display("FAIL div1_tick: got %b want 1", bs.pix_tick); end
    for (int c = 1; c <= 96; c++) begin
      step(1);
      nm  = "";
      got = '0;
      exp = '0;
      case (c)
        3:  begin nm = "s_vd_h3";  got = {bs.h_count, bs.vd_on};  exp = {11'd3, 1'b1}; end
        4:  begin nm = "s_h4";     got = {bs.h_count, bs.h_sync, bs.vd_on}; exp = {11'd4, 2'b00}; end
        5:  begin nm = "s_hs_h5";  got = {bs.h_count, bs.h_sync}; exp = {11'd5, 1'b1}; end
        6:  begin nm = "s_hs_h6";  got = {bs.h_count, bs.h_sync}; exp = {11'd6, 1'b1}; end
        7:  begin nm = "s_hs_h7";  got = {bs.h_count, bs.h_sync}; exp = {11'd7, 1'b0}; end
        8:  begin nm = "s_sol";    got = {bs.h_count, bs.v_count, bs.sol}; exp = {11'd0, 11'd1, 1'b1}; end
        9:  begin nm = "s_sol_off"; got = {bs.h_count, bs.sol};   exp = {11'd1, 1'b0}; end
        16: begin nm = "s_vd_v2";  got = {bs.v_count, bs.vd_on};  exp = {11'd2, 1'b1}; end
        24: begin nm = "s_vd_v3";  got = {bs.v_count, bs.vd_on};  exp = {11'd3, 1'b0}; end
        32: begin nm = "s_vs_v4";  got = {bs.v_count, bs.v_sync}; exp = {11'd4, 1'b1}; end
        40: begin nm = "s_vs_v5";  got = {bs.v_count, bs.v_sync}; exp = {11'd5, 1'b0}; end
        47: begin nm = "s_eof";    got = {bs.h_count, bs.v_count, bs.eof, bs.sof}; exp = {11'd7, 11'd5, 2'b10}; end
        48: begin nm = "s_sof";    got = {bs.h_count, bs.v_count, bs.eof, bs.sof, bs.frame_count};
                  exp = {11'd0, 11'd0, 2'b01, 16'd1}; end
        96: begin nm = "s_sof2";   got = {bs.sof, bs.frame_count}; exp = {1'b1, 16'd2}; end
        default: ;
      endcase
      if (nm != "") begin
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", nm, c, got, exp);
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    bit seen;
    bs.en = 1'b0;
    force dut_s.frame_count_q = 16'hFFFF;
    #1;
    release dut_s.frame_count_q;
    step(1);
    n_tests++;
    if (bs.frame_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL fc_preload: got 0x%0h want 0xffff", bs.frame_count);
    end
    bs.en = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1);
      seen = bs.sof;
    end
    n_tests++;
    if ({seen, bs.frame_count} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL fc_wrap: got sof_seen=%b f=0x%0h, want 1 0x0000", seen, bs.frame_count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_d   = 1'b1;
    rst_s   = 1'b1;
    bd.en   = 1'b1;
    bs.en   = 1'b1;
    step(3);
    test_reset();
    test_pix_tick();
    test_hline();
    test_enable_hold();
    test_vsync_frame();
    test_mid_reset();
    test_small();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameter CLK_DIV, default 4: clk cycles per pixel, legal range 1..16.
REQ-010 Parameter H_POL, default 0: h_sync asserted level (0 = active-low, 1 = active-high).
REQ-011 Parameter V_POL, default 0: v_sync asserted level, encoded as for H_POL.
REQ-012 Parameter CW, default 11: width of h_count and v_count.
REQ-013 Port clk, input, 1 bit: clock.
REQ-014 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-015 Port en, input, 1 bit: run enable; while low, all timing state holds.
REQ-016 Port pix_tick, output, 1 bit: pixel-rate strobe.
REQ-017 Port h_count, output, CW bits: pixel index within the line.
REQ-018 Port v_count, output, CW bits: line index within the frame.
REQ-019 Port h_sync and v_sync, outputs, 1 bit each: sync pulses at the parameterised polarity.
REQ-020 Port vd_on, output, 1 bit: active video.
REQ-021 Port sol, output, 1 bit: start-of-line strobe.
REQ-022 Port sof, output, 1 bit: start-of-frame strobe.
REQ-023 Port eof, output, 1 bit: end-of-frame strobe.
REQ-024 Port frame_count, output, 16 bits: count of completed frames.

Function
REQ-025 Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL be at most 2^CW.
REQ-026 Divider: a counter runs 0..CLK_DIV-1 while en=1; pix_tick SHALL be high for exactly the clk cycle in which the divider equals CLK_DIV-1; if CLK_DIV=1, pix_tick = en.
REQ-027 On each pix_tick: h_count increments, and wraps from H_TOTAL-1 to 0.
REQ-028 When h_count wraps: v_count increments, and wraps from V_TOTAL-1 to 0; v_count changes only on the pix_tick on which h_count wraps.
REQ-029 When en=0: the divider, h_count, v_count and frame_count hold; pix_tick=0; sol, sof and eof=0; h_sync, v_sync and vd_on hold their last values.
REQ-030 h_sync SHALL equal H_POL exactly while H_ACTIVE+H_FP <= h_count <= H_ACTIVE+H_FP+H_SYNC-1, and ~H_POL otherwise.
REQ-031 v_sync SHALL equal V_POL exactly while V_ACTIVE+V_FP <= v_count <= V_ACTIVE+V_FP+V_SYNC-1, and ~V_POL otherwise.
REQ-032 vd_on SHALL be 1 exactly while h_count < H_ACTIVE and v_count < V_ACTIVE.
REQ-033 All of h_sync, v_sync, vd_on, sol, sof and eof SHALL be registered, decoded from next-count values, so each is glitch-free and matches the h_count/v_count displayed in the same clk cycle.
REQ-034 sol SHALL be high for one clk cycle, the cycle in which h_count becomes 0.
REQ-035 sof SHALL be high for one clk cycle, the cycle in which h_count and v_count both become 0.
REQ-036 eof SHALL be high for one clk cycle, the cycle in which h_count=H_TOTAL-1 and v_count=V_TOTAL-1 are first displayed.
REQ-037 frame_count SHALL increment in the same cycle sof asserts, and wrap from 0xFFFF to 0.
REQ-038 Counter advance latency: h_count/v_count SHALL update on the clk edge that ends the pix_tick cycle, i.e. new values are visible the cycle after pix_tick.

Reset
REQ-039 While rst=1, regardless of en or clk: divider=0, h_count=0, v_count=0, frame_count=0, pix_tick=0, h_sync=~H_POL, v_sync=~V_POL, vd_on=1, sol=0, sof=0, eof=0.
REQ-040 After rst deasserts with en=1, the first pix_tick SHALL occur CLK_DIV clk cycles later; sof SHALL NOT assert for the reset-initial frame.
REQ-041 rst asserted mid-frame SHALL abort the frame immediately; timing restarts from (0,0) with frame_count=0.

Verification
REQ-042 Defaults, en=1: h_count 799->0 with v_count incremented; v_count 524->0 with sof=1 and frame_count 0->1; pix_tick period = 4 clk.
REQ-043 Defaults: h_sync=0 exactly for h_count 656..751; v_sync=0 exactly for v_count 490..491; vd_on=0 at h_count=640 and at v_count=480.
REQ-044 H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, H_POL=V_POL=1: line = 8 clk, frame = 48 clk; h_sync=1 at h_count 5..6; eof at (7,5); sof on the next cycle.
REQ-045 Drop en for 10 clk mid-line at h_count=300: counts and frame_count are frozen, pix_tick=0; on en=1, h_count resumes at 301 after CLK_DIV clk.
REQ-046 Assert rst at (h_count=400, v_count=200, frame_count=3): all outputs take their REQ-039 values in the same cycle; after release, first h_count=1 appears 4 clk later.
REQ-047 Preload or run to frame_count=0xFFFF, then complete a frame: frame_count reads 0x0000 in the cycle sof=1.
